// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART register responder
//
// Purpose: state encoding, protocol constants and the command-byte decode
// helper used by uart_reg_responder and uart_regbank.
// Ports: none (package).

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GET_DATA   = 3'd1,
    ST_SEND_START = 3'd2,
    ST_SEND_BUSY  = 3'd3,
    ST_SEND_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] CMD_TAG = 3'b010;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;
  localparam logic [2:0] ID_ADDR = 3'd7;

  // A command is well formed when the tag matches and the reserved bit is 0.
  function automatic logic cmd_is_valid(input logic [7:0] b);
    return (b[6:4] == CMD_TAG) && !b[3];
  endfunction

endpackage

// File: rtl/uart_regbank.sv
// rtl/uart_regbank.sv - 7x8 register storage with write port and read mux
//
// Purpose: holds registers 0-6; register 7 is a read-only ID constant.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data - write port (writes to ID_ADDR are ignored)
//   rd_addr, rd_data        - combinational read port
//   regs_out        - registers 0-6 flattened, reg n at [8n+7:8n]

module uart_regbank
  import uart_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [55:0] regs_out
);

  logic [55:0] regs_q;
  logic [55:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != ID_ADDR)) begin
      for (int n = 0; n < 7; n++) begin
        if (wr_addr == 3'(n)) regs_d[n*8 +: 8] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '0;
    else      regs_q <= regs_d;
  end

  always_comb begin
    rd_data = ID_VALUE;
    for (int n = 0; n < 7; n++) begin
      if (rd_addr == 3'(n)) rd_data = regs_q[n*8 +: 8];
    end
  end

  assign regs_out = regs_q;

endmodule

// File: rtl/uart_reg_responder.sv
// rtl/uart_reg_responder.sv - byte command decoder and responder for a UART register port
//
// Purpose: decodes 1-2 byte read/write commands from the UART receiver,
// updates the register bank and answers through the UART transmitter.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   rx_data, rx_valid    - received byte and its one-cycle strobe
//   tx_busy              - transmitter busy
//   tran_start, trans_data - one-cycle transmit request and byte
//   regs_out             - registers 0-6 flattened
//   resp_busy            - high whenever the FSM is not idle
//   overrun, timeout     - sticky error flags
//   err_clr              - synchronous clear of the error flags

module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ID_VALUE       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic        tran_start,
  output logic [7:0]  trans_data,
  output logic [55:0] regs_out,
  output logic        resp_busy,
  output logic        overrun,
  output logic        timeout,
  input  logic        err_clr
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       trans_data_q, trans_data_d;
  logic             tran_start_q, tran_start_d;
  logic             resp_busy_q;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic             wr_en;
  logic [7:0]       rd_data;
  logic             expired;
  logic             set_ovr;
  logic             set_to;

  uart_regbank #(.ID_VALUE(ID_VALUE)) u_regbank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (addr_q),
    .wr_data  (rx_data),
    .rd_addr  (rx_data[2:0]),
    .rd_data  (rd_data),
    .regs_out (regs_out)
  );

  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    trans_data_d = trans_data_q;
    wr_en        = 1'b0;
    set_ovr      = 1'b0;
    set_to       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          // Any well-formed write, including the protected address, waits
          // for its data byte so the stream stays in frame.
          if (cmd_is_valid(rx_data) && rx_data[7]) begin
            state_d = ST_GET_DATA;
            addr_d  = rx_data[2:0];
          end else begin
            state_d      = ST_SEND_START;
            trans_data_d = cmd_is_valid(rx_data) ? rd_data : NAK;
          end
        end
      end
      ST_GET_DATA: begin
        if (rx_valid) begin
          state_d = ST_SEND_START;
          if (addr_q == ID_ADDR) begin
            trans_data_d = NAK;
          end else begin
            wr_en        = 1'b1;
            trans_data_d = ACK;
          end
        end else if (expired) begin
          state_d = ST_IDLE;
          set_to  = 1'b1;
        end
      end
      ST_SEND_START: begin
        // Leave only after the cycle in which the request was presented.
        if (tran_start_q) state_d = ST_SEND_BUSY;
        set_ovr = rx_valid;
      end
      ST_SEND_BUSY: begin
        if (tx_busy) begin
          state_d = ST_SEND_DONE;
        end else if (expired) begin
          state_d = ST_IDLE;
          set_to  = 1'b1;
        end
        set_ovr = rx_valid;
      end
      ST_SEND_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
        set_ovr = rx_valid;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counting only while staying in a wait state; any entry starts from 0.
    if (((state_q == ST_GET_DATA) || (state_q == ST_SEND_BUSY)) && (state_d == state_q))
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = '0;

    // Registered request: raised for the SEND_START cycle, deferred while the
    // transmitter is still busy.
    tran_start_d = (state_d == ST_SEND_START) && !tran_start_q && !tx_busy;

    overrun_d = set_ovr | (overrun_q & ~err_clr);
    timeout_d = set_to  | (timeout_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      trans_data_q <= '0;
      tran_start_q <= 1'b0;
      resp_busy_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      trans_data_q <= trans_data_d;
      tran_start_q <= tran_start_d;
      resp_busy_q  <= (state_d != ST_IDLE);
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign tran_start = tran_start_q;
  assign trans_data = trans_data_q;
  assign resp_busy  = resp_busy_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level command responder on the parallel side of the UART. It consumes received bytes from the receiver's `o_data`/`o_data_valid`, decodes a 1–2 byte read/write protocol, and updates an 8-entry register bank. It answers each command by driving the transmitter's `tran_start`/`trans_data` and honouring its `tx_busy`. This makes the UART a remotely controllable register port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000: clk cycles allowed while waiting for a write data byte or for `tx_busy` to rise.
- `ID_VALUE`, default 8'hA5: read-only contents of register 7.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `rx_data` input 8: received byte; connects to the receiver's `o_data`.
- `rx_valid` input 1: one-cycle pulse, `rx_data` valid; connects to `o_data_valid`.
- `tx_busy` input 1: transmitter busy.
- `tran_start` output 1: one-cycle transmit request.
- `trans_data` output 8: byte to transmit.
- `regs_out` output 56: registers 0–6 flattened; reg n occupies bits [8n+7:8n].
- `resp_busy` output 1: high in any state other than IDLE.
- `overrun` output 1: sticky; a byte arrived while the block could not accept it.
- `timeout` output 1: sticky; a wait timed out.
- `err_clr` input 1: synchronous clear of `overrun` and `timeout`.

## Operation
- Command byte layout: [7] = W (1 = write, 0 = read), [6:4] = tag, must be 3'b010, [3] = 0, [2:0] = addr.
- Valid read (0x20–0x27): respond with reg[addr]. Reg 7 returns `ID_VALUE`.
- Valid write (0xA0–0xA6): go to GET_DATA. On the next byte, reg[addr] is loaded and the response is ACK 0x06.
- Write to addr 7 (0xA7): data byte is still consumed; response is NAK 0x15; no register change.
- Bad tag or [3] = 1: response is NAK 0x15 immediately; no data byte is expected.
- States: IDLE, GET_DATA, SEND_START, SEND_BUSY, SEND_DONE.
  - IDLE --rx_valid--> GET_DATA (valid write) or SEND_START (all other bytes).
  - GET_DATA --rx_valid--> SEND_START.
  - GET_DATA --timeout--> IDLE: no response, `timeout` set.
  - SEND_START --> SEND_BUSY (`tran_start` high for this single cycle).
  - SEND_BUSY --tx_busy=1--> SEND_DONE.
  - SEND_BUSY --timeout--> IDLE: `timeout` set.
  - SEND_DONE --tx_busy=0--> IDLE.
- Entering SEND_START while `tx_busy` = 1: hold in SEND_START and delay `tran_start` until `tx_busy` = 0.
- `rx_valid` in SEND_START, SEND_BUSY or SEND_DONE: byte dropped, `overrun` set.
- Timeout counter: cleared on entry to GET_DATA and on entry to SEND_BUSY; expires when it reaches `TIMEOUT_CYCLES` − 1.
- `err_clr` and a new error in the same cycle: the set wins.

## Timing
- Reset values: all registers 0, `regs_out` = 0, `trans_data` = 0, `tran_start` = 0, `resp_busy` = 0, `overrun` = 0, `timeout` = 0, state IDLE.
- All outputs are registered.
- Latency: `rx_valid` high in cycle N → `tran_start` high in cycle N+1 (if `tx_busy` = 0). Write data is visible on `regs_out` in cycle N+1.
- `trans_data` is loaded on entry to SEND_START and held stable until the return to IDLE.
- `rst` asserted mid-command or mid-transmit: immediate return to reset values; a partial command is discarded.
- Back-to-back commands: a byte arriving in the cycle IDLE is re-entered is accepted normally.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding;
  - constants `CMD_TAG` = 3'b010, `ACK` = 8'h06, `NAK` = 8'h15, `ID_ADDR` = 3'd7.
- Natural sub-module: `uart_regbank` (7×8 storage, write port, read mux with the ID constant).
- FSM and timeout counter stay in the top.
- Target size: about 200 lines.

## Test plan
- Write then read: rx 0xA3, 0x5C → `trans_data` 0x06, `regs_out`[31:24] = 0x5C. Then rx 0x23 → `trans_data` 0x5C with `tran_start` one cycle after `rx_valid`.
- ID and protected write: rx 0x27 → 0xA5. Rx 0xA7, 0x11 → NAK 0x15; reg 7 read still returns 0xA5.
- Bad command: rx 0x38 and 0xFF → each produces NAK 0x15; no state left in GET_DATA.
- Timeout: `TIMEOUT_CYCLES` = 16, rx 0xA1, then no byte for 16 cycles → IDLE, `timeout` = 1, no `tran_start`. `err_clr` → 0.
- Overrun and busy: hold `tx_busy` = 1 and rx 0x20 → `tran_start` is delayed until `tx_busy` falls. Rx 0x21 during SEND_DONE → `overrun` = 1, byte dropped.
- Async reset asserted in GET_DATA after rx 0xA2 → outputs reset. Then rx 0x22 → 0x00.
